// File: rtl/game_scoreboard_pkg.sv
// Shared types and default constants for the memory-game scoreboard.
// Optional feature macro used by this slice: GAME_SCOREBOARD_BONUS_LIFE_EN.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    LVL_UP,
    WIN,
    OVER
  } game_state_t;

  localparam int LIVES_INIT_DEF = 3;
  localparam int LIVES_MAX_DEF  = 7;
  localparam int MAX_LEVEL_DEF  = 3;

  // Score multiplier is chosen from the streak as it was before the current hit.
  function automatic int unsigned streak_mult(input int unsigned streak);
    if (streak < 4)
      return 1;
    else if (streak < 8)
      return 2;
    else
      return 4;
  endfunction

endpackage

// File: rtl/game_scoreboard_if.sv
// Step-result inputs and display/control outputs of the game scoreboard.
// bonus_life exists only when GAME_SCOREBOARD_BONUS_LIFE_EN is defined.
interface game_scoreboard_if #(
  parameter int SCORE_W  = 14,
  parameter int STREAK_W = 5
);
  logic                start;
  logic                step_valid;
  logic                hit;
  logic                level_done;
  logic [SCORE_W-1:0]  score;
  logic [STREAK_W-1:0] streak;
  logic [2:0]          lives;
  logic [1:0]          level;
  logic                level_rst;
  logic                level_up;
  logic                lose_life;
  logic                playing;
  logic                game_won;
  logic                game_over;
`ifdef GAME_SCOREBOARD_BONUS_LIFE_EN
  logic                bonus_life;

  modport master (
    output start, step_valid, hit, level_done,
    input  score, streak, lives, level, level_rst, level_up, lose_life,
           playing, game_won, game_over, bonus_life
  );

  modport slave (
    input  start, step_valid, hit, level_done,
    output score, streak, lives, level, level_rst, level_up, lose_life,
           playing, game_won, game_over, bonus_life
  );
`else
  modport master (
    output start, step_valid, hit, level_done,
    input  score, streak, lives, level, level_rst, level_up, lose_life,
           playing, game_won, game_over
  );

  modport slave (
    input  start, step_valid, hit, level_done,
    output score, streak, lives, level, level_rst, level_up, lose_life,
           playing, game_won, game_over
  );
`endif
endinterface

// File: rtl/game_scoreboard_sat_accum.sv
// Combinational saturating adder: result = clear ? 0 : min(value + increment, all-ones).
module sat_accum #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] increment,
  input  logic         clear,
  output logic [W-1:0] result
);

  logic [W:0] sum;

  assign sum = {1'b0, value} + {1'b0, increment};

  always_comb begin
    result = sum[W-1:0];
    if (clear)
      result = '0;
    else if (sum[W])
      result = '1;
  end

endmodule

// File: rtl/game_scoreboard.sv
// Memory-game scoreboard: scores level-FSM step results and sequences levels, win and game over.
// Define GAME_SCOREBOARD_BONUS_LIFE_EN to award a life on every 16th consecutive hit.
module game_scoreboard
  import game_pkg::*;
#(
  parameter int LIVES_INIT  = LIVES_INIT_DEF,
  parameter int LIVES_MAX   = LIVES_MAX_DEF,
  parameter int MAX_LEVEL   = MAX_LEVEL_DEF,
  parameter int SCORE_W     = 14,
  parameter int BASE_POINTS = 1,
  parameter int STREAK_W    = 5
) (
  input  logic         clk,
  input  logic         reset,
  game_scoreboard_if.slave bus
);

  game_state_t         state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d, score_nxt, points;
  logic [STREAK_W-1:0] streak_q, streak_d, streak_nxt;
  logic [2:0]          lives_q, lives_d;
  logic [1:0]          level_q, level_d;
  logic                level_rst_q, level_rst_d;
  logic                level_up_q, level_up_d;
  logic                lose_life_q, lose_life_d;
  logic                new_game, step, miss;
`ifdef GAME_SCOREBOARD_BONUS_LIFE_EN
  logic                bonus_q, bonus_d;
`endif

  assign new_game = bus.start && (state_q == IDLE || state_q == WIN || state_q == OVER);
  assign step     = bus.step_valid && (state_q == PLAY);
  assign miss     = step && !bus.hit;
  assign points   = SCORE_W'(BASE_POINTS * streak_mult(32'(streak_q)));

  sat_accum #(.W(SCORE_W)) score_acc (
    .value     (score_q),
    .increment (points),
    .clear     (new_game),
    .result    (score_nxt)
  );

  sat_accum #(.W(STREAK_W)) streak_acc (
    .value     (streak_q),
    .increment (STREAK_W'(1)),
    .clear     (new_game || miss),
    .result    (streak_nxt)
  );

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    streak_d    = streak_q;
    lives_d     = lives_q;
    level_d     = level_q;
    level_rst_d = 1'b0;
    level_up_d  = 1'b0;
    lose_life_d = 1'b0;
`ifdef GAME_SCOREBOARD_BONUS_LIFE_EN
    bonus_d     = 1'b0;
`endif
    case (state_q)
      IDLE, WIN, OVER: begin
        if (bus.start) begin
          state_d     = PLAY;
          score_d     = score_nxt;
          streak_d    = streak_nxt;
          lives_d     = 3'(LIVES_INIT);
          level_d     = 2'd1;
          level_rst_d = 1'b1;
        end
      end
      PLAY: begin
        if (bus.step_valid) begin
          streak_d = streak_nxt;
          if (bus.hit) begin
            score_d = score_nxt;
`ifdef GAME_SCOREBOARD_BONUS_LIFE_EN
            // Only a real increment landing on a multiple of 16 earns a life; a pinned streak does not.
            if (streak_nxt != streak_q && (int'(streak_nxt) % 16) == 0) begin
              bonus_d = 1'b1;
              if (lives_q < 3'(LIVES_MAX))
                lives_d = lives_q + 3'd1;
            end
`endif
            if (bus.level_done) begin
              level_up_d = 1'b1;
              state_d    = LVL_UP;
            end
          end else begin
            lose_life_d = 1'b1;
            lives_d     = lives_q - 3'd1;
            if (lives_q <= 3'd1) begin
              lives_d = 3'd0;
              state_d = OVER;
            end
          end
        end
      end
      LVL_UP: begin
        if (level_q == 2'(MAX_LEVEL)) begin
          state_d = WIN;
        end else begin
          level_d     = level_q + 2'd1;
          level_rst_d = 1'b1;
          state_d     = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      score_q     <= '0;
      streak_q    <= '0;
      lives_q     <= '0;
      level_q     <= '0;
      level_rst_q <= 1'b0;
      level_up_q  <= 1'b0;
      lose_life_q <= 1'b0;
`ifdef GAME_SCOREBOARD_BONUS_LIFE_EN
      bonus_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      streak_q    <= streak_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      level_rst_q <= level_rst_d;
      level_up_q  <= level_up_d;
      lose_life_q <= lose_life_d;
`ifdef GAME_SCOREBOARD_BONUS_LIFE_EN
      bonus_q     <= bonus_d;
`endif
    end
  end

  assign bus.score     = score_q;
  assign bus.streak    = streak_q;
  assign bus.lives     = lives_q;
  assign bus.level     = level_q;
  assign bus.level_rst = level_rst_q;
  assign bus.level_up  = level_up_q;
  assign bus.lose_life = lose_life_q;
  assign bus.playing   = (state_q == PLAY);
  assign bus.game_won  = (state_q == WIN);
  assign bus.game_over = (state_q == OVER);
`ifdef GAME_SCOREBOARD_BONUS_LIFE_EN
  assign bus.bonus_life = bonus_q;
`endif

endmodule

// File: tb/tb_game_scoreboard.sv
// Directed self-checking bench for game_scoreboard (main instance, a 4-bit score instance,
// and with GAME_SCOREBOARD_BONUS_LIFE_EN a LIVES_INIT=7 instance).
module tb_game_scoreboard;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  game_scoreboard_if #(.SCORE_W(14), .STREAK_W(5)) m ();
  game_scoreboard_if #(.SCORE_W(4),  .STREAK_W(5)) s ();

  game_scoreboard #(.SCORE_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m)
  );

  game_scoreboard #(.SCORE_W(4)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (s)
  );

`ifdef GAME_SCOREBOARD_BONUS_LIFE_EN
  game_scoreboard_if #(.SCORE_W(14), .STREAK_W(5)) f ();

  game_scoreboard #(.LIVES_INIT(7)) dut_full (
    .clk   (clk),
    .reset (reset),
    .bus   (f)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step(input logic h, input logic d);
    m.step_valid = 1'b1;
    m.hit        = h;
    m.level_done = d;
    tick();
    m.step_valid = 1'b0;
    m.hit        = 1'b0;
    m.level_done = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    m.start = 1'b0; m.step_valid = 1'b0; m.hit = 1'b0; m.level_done = 1'b0;
    s.start = 1'b0; s.step_valid = 1'b0; s.hit = 1'b0; s.level_done = 1'b0;
`ifdef GAME_SCOREBOARD_BONUS_LIFE_EN
    f.start = 1'b0; f.step_valid = 1'b0; f.hit = 1'b0; f.level_done = 1'b0;
`endif
    tick();
    tick();

    check("rst_score", 32'(m.score), 0);
    check("rst_streak", 32'(m.streak), 0);
    check("rst_lives", 32'(m.lives), 0);
    check("rst_level", 32'(m.level), 0);
    check("rst_flags", {29'd0, m.playing, m.game_won, m.game_over}, 0);
    check("rst_pulses", {29'd0, m.level_rst, m.level_up, m.lose_life}, 0);

    reset = 1'b0;
    tick();
    check("idle_hold_level", 32'(m.level), 0);

    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    check("start_lives", 32'(m.lives), 3);
    check("start_level", 32'(m.level), 1);
    check("start_score", 32'(m.score), 0);
    check("start_level_rst", 32'(m.level_rst), 1);
    check("start_playing", 32'(m.playing), 1);
    tick();
    check("level_rst_one_cycle", 32'(m.level_rst), 0);

    // 10 hits: +1 x4, +2 x4, +4 x2 = 20
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0);
      check("hit_no_lose_life", 32'(m.lose_life), 0);
      if (i == 4) check("score_after_4", 32'(m.score), 4);
      if (i == 8) check("score_after_8", 32'(m.score), 12);
    end
    check("score_after_10", 32'(m.score), 20);
    check("streak_after_10", 32'(m.streak), 10);

    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    check("start_in_play_score", 32'(m.score), 20);
    check("start_in_play_level_rst", 32'(m.level_rst), 0);
    check("start_in_play_lives", 32'(m.lives), 3);

    step(1'b0, 1'b0);
    check("miss1_lose_life", 32'(m.lose_life), 1);
    check("miss1_lives", 32'(m.lives), 2);
    check("miss1_streak", 32'(m.streak), 0);
    check("miss1_score", 32'(m.score), 20);
    tick();
    check("lose_life_one_cycle", 32'(m.lose_life), 0);
    step(1'b0, 1'b1);
    check("miss2_lives", 32'(m.lives), 1);
    check("miss2_no_level_up", 32'(m.level_up), 0);
    step(1'b0, 1'b0);
    check("miss3_lose_life", 32'(m.lose_life), 1);
    check("miss3_lives", 32'(m.lives), 0);
    check("miss3_game_over", 32'(m.game_over), 1);
    check("miss3_playing", 32'(m.playing), 0);
    step(1'b1, 1'b0);
    check("over_ignores_step", 32'(m.score), 20);

    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    check("restart_lives", 32'(m.lives), 3);
    check("restart_score", 32'(m.score), 0);
    check("restart_game_over", 32'(m.game_over), 0);

    step(1'b1, 1'b1);
    check("lvl1_level_up", 32'(m.level_up), 1);
    check("lvl1_level_hold", 32'(m.level), 1);
    check("lvl1_score", 32'(m.score), 1);
    step(1'b1, 1'b0);
    check("lvl2_level", 32'(m.level), 2);
    check("lvl2_level_rst", 32'(m.level_rst), 1);
    check("lvl2_level_up_drop", 32'(m.level_up), 0);
    check("lvl_up_ignores_step", 32'(m.score), 1);
    step(1'b1, 1'b1);
    tick();
    check("lvl3_level", 32'(m.level), 3);
    step(1'b1, 1'b1);
    check("lvl3_level_up", 32'(m.level_up), 1);
    tick();
    check("win_flag", 32'(m.game_won), 1);
    check("win_level", 32'(m.level), 3);
    check("win_no_level_rst", 32'(m.level_rst), 0);
    check("win_score", 32'(m.score), 3);

    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    check("win_restart_level", 32'(m.level), 1);
    check("win_restart_won", 32'(m.game_won), 0);

    step(1'b1, 1'b0);
    check("pre_reset_score", 32'(m.score), 1);
    reset = 1'b1;
    m.step_valid = 1'b1;
    m.hit = 1'b1;
    tick();
    m.step_valid = 1'b0;
    m.hit = 1'b0;
    check("midreset_score", 32'(m.score), 0);
    check("midreset_lives", 32'(m.lives), 0);
    check("midreset_level", 32'(m.level), 0);
    check("midreset_streak", 32'(m.streak), 0);
    check("midreset_playing", 32'(m.playing), 0);
    reset = 1'b0;
    tick();

    // Score sequence 1,2,3,4,6,8,10,12,then pinned at 15
    s.start = 1'b1;
    tick();
    s.start = 1'b0;
    s.step_valid = 1'b1;
    s.hit = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    s.step_valid = 1'b0;
    s.hit = 1'b0;
    check("sat_score", 32'(s.score), 15);
    check("sat_streak", 32'(s.streak), 20);

`ifdef GAME_SCOREBOARD_BONUS_LIFE_EN
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    check("bonus_before_16", 32'(m.bonus_life), 0);
    check("lives_before_16", 32'(m.lives), 3);
    step(1'b1, 1'b0);
    check("bonus_on_16", 32'(m.bonus_life), 1);
    check("lives_on_16", 32'(m.lives), 4);
    tick();
    check("bonus_one_cycle", 32'(m.bonus_life), 0);

    f.start = 1'b1;
    tick();
    f.start = 1'b0;
    f.step_valid = 1'b1;
    f.hit = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    f.step_valid = 1'b0;
    f.hit = 1'b0;
    check("full_bonus_pulse", 32'(f.bonus_life), 1);
    check("full_lives_capped", 32'(f.lives), 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
